// File: rtl/key_input_pkg.sv
// Shared types and helpers for the key/switch input conditioner.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int SYNC_STAGES = 2;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one raw push-button and debounces it; emits a single-cycle
// accept pulse per stable press, never repeating while the key is held.
module key_debounce
  import key_input_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   key_s;
  key_state_e             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   accept_reg, accept_next;

  assign key_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_reg   <= '0;
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      accept_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], i_key};
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      accept_reg <= accept_next;
    end
  end

  // The counter only runs in the two WAIT states and every WAIT state exits
  // on CNT_LAST, so it can never wrap.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = PRESSED;
          cnt_next    = '0;
          accept_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign o_accept = accept_reg;

endmodule

// File: rtl/key_input_ctrl.sv
// Board-side conditioner for the Lab1 Top: debounced start/control pulses
// with start-first arbitration, and a debounced one-hot index selection.
module key_input_ctrl
  import key_input_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_start,
  input  logic       i_key_control,
  input  logic [1:0] i_sw_index,
  output logic       o_start,
  output logic       o_control,
  output logic       o_index_0,
  output logic       o_index_1,
  output logic       o_index_2,
  output logic       o_index_3
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic start_acc, control_acc;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_key    (i_key_start),
    .o_accept (start_acc)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_control (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_key    (i_key_control),
    .o_accept (control_acc)
  );

  logic [SYNC_STAGES-1:0] idx_sync_reg [2];
  logic [1:0]             sw_s;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_idx_sync
      always_ff @(posedge i_clk) begin
        if (i_rst) idx_sync_reg[gi] <= '0;
        else       idx_sync_reg[gi] <= {idx_sync_reg[gi][SYNC_STAGES-2:0], i_sw_index[gi]};
      end
      assign sw_s[gi] = idx_sync_reg[gi][SYNC_STAGES-1];
    end
  endgenerate

  logic [1:0]       committed_reg, committed_next;
  logic [1:0]       cand_reg, cand_next;
  logic [CNT_W-1:0] icnt_reg, icnt_next;
  logic [3:0]       index_oh_reg;
  logic             start_reg, start_next;
  logic             control_reg, control_next;
  logic             pending_reg, pending_next;

  // A non-zero count means cand_reg holds the value being timed.
  always_comb begin
    committed_next = committed_reg;
    cand_next      = cand_reg;
    icnt_next      = icnt_reg;
    if (sw_s == committed_reg) begin
      icnt_next = '0;
    end else if (icnt_reg != '0 && sw_s == cand_reg) begin
      if (icnt_reg == CNT_LAST) begin
        committed_next = cand_reg;
        icnt_next      = '0;
      end else begin
        icnt_next = icnt_reg + CNT_W'(1);
      end
    end else begin
      cand_next = sw_s;
      icnt_next = CNT_W'(1);
    end
  end

  // Start wins a tie; control is deferred one cycle and merges with any
  // further control accept arriving while it waits.
  always_comb begin
    start_next   = start_acc;
    control_next = 1'b0;
    pending_next = 1'b0;
    if (start_acc) begin
      pending_next = pending_reg | control_acc;
    end else begin
      control_next = pending_reg | control_acc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      committed_reg <= 2'd0;
      cand_reg      <= 2'd0;
      icnt_reg      <= '0;
      index_oh_reg  <= 4'b0001;
      start_reg     <= 1'b0;
      control_reg   <= 1'b0;
      pending_reg   <= 1'b0;
    end else begin
      committed_reg <= committed_next;
      cand_reg      <= cand_next;
      icnt_reg      <= icnt_next;
      index_oh_reg  <= onehot4(committed_reg);
      start_reg     <= start_next;
      control_reg   <= control_next;
      pending_reg   <= pending_next;
    end
  end

  assign o_start   = start_reg;
  assign o_control = control_reg;
  assign o_index_0 = index_oh_reg[0];
  assign o_index_1 = index_oh_reg[1];
  assign o_index_2 = index_oh_reg[2];
  assign o_index_3 = index_oh_reg[3];

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed, table-driven bench for key_input_ctrl with DEBOUNCE_CYCLES = 4.
module tb_key_input_ctrl;

  localparam int DB = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_key_start;
  logic       i_key_control;
  logic [1:0] i_sw_index;
  logic       o_start, o_control;
  logic       o_index_0, o_index_1, o_index_2, o_index_3;

  key_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_key_start   (i_key_start),
    .i_key_control (i_key_control),
    .i_sw_index    (i_sw_index),
    .o_start       (o_start),
    .o_control     (o_control),
    .o_index_0     (o_index_0),
    .o_index_1     (o_index_1),
    .o_index_2     (o_index_2),
    .o_index_3     (o_index_3)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic       ks;
    logic       kc;
    logic [1:0] sw;
    logic       es;
    logic       ec;
    logic [3:0] eidx;
  } vec_t;

  vec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [3:0] idx_now();
    return {o_index_3, o_index_2, o_index_1, o_index_0};
  endfunction

  task automatic check(string nm, int k, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, k, act, exp);
    end
  endtask

  task automatic add(logic rst, logic ks, logic kc, logic [1:0] sw,
                     logic es, logic ec, logic [3:0] eidx);
    vec_t v;
    v.rst = rst; v.ks = ks; v.kc = kc; v.sw = sw;
    v.es = es; v.ec = ec; v.eidx = eidx;
    q.push_back(v);
  endtask

  // Row k drives the inputs sampled at edge k; its expectations are the
  // outputs right after that edge.
  task automatic run(string nm);
    foreach (q[k]) begin
      i_rst         = q[k].rst;
      i_key_start   = q[k].ks;
      i_key_control = q[k].kc;
      i_sw_index    = q[k].sw;
      @(negedge i_clk);
      $display("%s[%0d] rst=%b ks=%b kc=%b sw=%0d -> start=%b ctrl=%b idx=%b",
               nm, k, q[k].rst, q[k].ks, q[k].kc, q[k].sw, o_start, o_control, idx_now());
      check({nm, ".start"}, k, {3'b0, o_start},   {3'b0, q[k].es});
      check({nm, ".ctrl"},  k, {3'b0, o_control}, {3'b0, q[k].ec});
      check({nm, ".index"}, k, idx_now(),         q[k].eidx);
    end
    q.delete();
  endtask

  initial begin
    int got;
    i_rst = 1'b1; i_key_start = 1'b0; i_key_control = 1'b0; i_sw_index = 2'd0;
    @(negedge i_clk);
    @(negedge i_clk);
    $display("reset -> start=%b ctrl=%b idx=%b", o_start, o_control, idx_now());
    check("reset.start", 0, {3'b0, o_start},   4'd0);
    check("reset.ctrl",  0, {3'b0, o_control}, 4'd0);
    check("reset.index", 0, idx_now(),         4'b0001);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Clean press held 20 cycles: single pulse after edge 6, nothing on release.
    for (int i = 0; i < 30; i++) add(0, i < 20, 0, 2'd0, i == 6, 0, 4'b0001);
    run("clean");

    // Bounce 1,0,1,0 then held: last rising sample at row 4 -> pulse at row 10.
    for (int i = 0; i < 24; i++)
      add(0, 0, (i == 0 || i == 2 || (i >= 4 && i < 14)), 2'd0, 0, i == 10, 4'b0001);
    run("bounce");

    // Three-cycle glitch is one short of the debounce window.
    for (int i = 0; i < 12; i++) add(0, 0, i < 3, 2'd0, 0, 0, 4'b0001);
    run("glitch");

    // Release bounce: low for 3 cycles in the middle of a hold, no extra pulse.
    for (int i = 0; i < 30; i++)
      add(0, (i < 10 || (i >= 13 && i < 18)), 0, 2'd0, i == 6, 0, 4'b0001);
    run("relbounce");

    // Simultaneous press: start at row 6, control deferred to row 7.
    for (int i = 0; i < 25; i++) add(0, i < 15, i < 15, 2'd0, i == 6, i == 7, 4'b0001);
    run("simul");

    // Index 0 -> 2, then back to 0.
    for (int i = 0; i < 12; i++) add(0, 0, 0, 2'd2, 0, 0, (i >= 6) ? 4'b0100 : 4'b0001);
    run("idx2");
    for (int i = 0; i < 12; i++) add(0, 0, 0, 2'd0, 0, 0, (i >= 6) ? 4'b0001 : 4'b0100);
    run("idx0");

    // Two-cycle excursion to 3 is rejected.
    for (int i = 0; i < 12; i++) add(0, 0, 0, (i < 2) ? 2'd3 : 2'd0, 0, 0, 4'b0001);
    run("idxglitch");

    // Candidate 1 for two cycles then 3: count restarts, commit shows at row 8.
    for (int i = 0; i < 14; i++) add(0, 0, 0, (i < 2) ? 2'd1 : 2'd3, 0, 0, (i >= 8) ? 4'b1000 : 4'b0001);
    run("idxrestart");
    for (int i = 0; i < 10; i++) add(0, 0, 0, 2'd0, 0, 0, (i >= 6) ? 4'b0001 : 4'b1000);
    run("idxback");

    // Reset while start is in PRESS_WAIT; key held through reset re-pulses 6 after release.
    for (int i = 0; i < 26; i++)
      add((i == 4 || i == 5), i < 20, 0, 2'd0, i == 12, 0, 4'b0001);
    run("rstmid");

    // Reset right after the start pulse drops the pending control; both re-pulse.
    for (int i = 0; i < 30; i++)
      add(i == 7, i < 20, i < 20, 2'd0, (i == 6 || i == 14), i == 15, 4'b0001);
    run("rstpend");

    // Bounded wait for a start pulse, measuring latency from the sampling edge.
    i_key_start = 1'b1;
    got = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_start) begin
        got = c;
        break;
      end
    end
    $display("latency: start pulse after edge %0d", got);
    check("latency", 0, got[3:0], 4'(2 + DB));
    n_cmp++;
    if (got < 0) begin
      n_bad++;
      $display("FAIL latency.timeout: got no pulse within 20 cycles, expected one");
    end
    @(negedge i_clk);
    check("latency.single", 0, {3'b0, o_start}, 4'd0);
    i_key_start = 1'b0;
    repeat (10) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
